// File: rtl/sort_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sort_sequencer                                                |
// | Purpose  : Buffers a DEPTH-word burst, bubble-sorts it ascending with a  |
// |            single shared comparator, then streams it back out.           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sort_sequencer #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int CW = $clog2(DEPTH);
  localparam logic [CW-1:0] c_top  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] c_last = CW'(DEPTH - 2);

  typedef enum logic [1:0] {
    s_load  = 2'd0,
    s_sort  = 2'd1,
    s_drain = 2'd2
  } state_t;

  state_t        r_state, w_state_nx;
  logic [N-1:0]  r_mem [DEPTH];
  logic [CW-1:0] r_wr_ptr, r_rd_ptr, r_pass, r_idx;
  logic          r_swap;

  logic [CW-1:0] w_idx_nx, w_idx_end;
  logic [N:0]    w_diff;
  logic          w_lt, w_pass_end, w_sort_done;

  // Shared comparator: borrow out of mem[idx+1]-mem[idx] means a strict less-than.
  assign w_idx_nx   = r_idx + 1'b1;
  assign w_diff     = {1'b0, r_mem[w_idx_nx]} - {1'b0, r_mem[r_idx]};
  assign w_lt       = |(w_diff >> N);
  assign w_idx_end  = c_last - r_pass;
  assign w_pass_end = (r_idx == w_idx_end);
  assign w_sort_done = w_pass_end && (!(r_swap || w_lt) || (r_pass == c_last));

  assign in_ready  = rst_n && (r_state == s_load);
  assign busy      = (r_state == s_sort);
  assign out_valid = (r_state == s_drain);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign out_last  = out_valid && (r_rd_ptr == c_top);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= s_load;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      s_load:  if (in_valid && (r_wr_ptr == c_top))  w_state_nx = s_sort;
      s_sort:  if (w_sort_done)                      w_state_nx = s_drain;
      s_drain: if (out_ready && (r_rd_ptr == c_top)) w_state_nx = s_load;
      default: w_state_nx = s_load;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_pass   <= '0;
      r_idx    <= '0;
      r_swap   <= 1'b0;
    end else begin
      case (r_state)
        s_load: begin
          if (in_valid) r_wr_ptr <= (r_wr_ptr == c_top) ? '0 : r_wr_ptr + 1'b1;
        end
        s_sort: begin
          if (w_sort_done) begin
            r_pass <= '0;
            r_idx  <= '0;
            r_swap <= 1'b0;
          end else if (w_pass_end) begin
            r_pass <= r_pass + 1'b1;
            r_idx  <= '0;
            r_swap <= 1'b0;
          end else begin
            r_idx  <= w_idx_nx;
            r_swap <= r_swap || w_lt;
          end
        end
        s_drain: begin
          if (out_ready) r_rd_ptr <= (r_rd_ptr == c_top) ? '0 : r_rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Storage is never reset; its contents are only meaningful within a burst.
  always_ff @(posedge clk) begin
    if ((r_state == s_load) && in_valid) begin
      r_mem[r_wr_ptr] <= in_data;
    end else if ((r_state == s_sort) && w_lt) begin
      r_mem[r_idx]    <= r_mem[w_idx_nx];
      r_mem[w_idx_nx] <= r_mem[r_idx];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sort_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sort_sequencer                                             |
// | Purpose  : Directed self-checking bench for sort_sequencer (N=4,DEPTH=4).|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_sort_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic       out_last;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  sort_sequencer #(.N(4), .DEPTH(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Words are packed first-in at [15:12]; inputs change on falling edges.
  task automatic load4(input logic [15:0] w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w[15-4*i -: 4];
      chk("load_in_ready", in_ready, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_burst(input logic [15:0] w, input logic [15:0] exp,
                           input int exp_busy, input bit stall, input bit junk);
    int         cnt;
    int         guard;
    int         k;
    int         c;
    logic [3:0] held;
    bit         was_stalled;
    load4(w);
    in_valid = junk;
    in_data  = 4'b0000;
    cnt = 0;
    guard = 0;
    while (!out_valid && guard < 100) begin
      if (busy) begin
        cnt++;
        chk("sort_in_ready", in_ready, 0);
      end
      @(negedge clk);
      guard++;
    end
    chk("sort_timeout", (guard < 100), 1);
    chk("busy_at_drain", busy, 0);
    if (exp_busy >= 0) chk("busy_cycles", cnt, exp_busy);
    k = 0;
    c = 0;
    held = 4'd0;
    was_stalled = 1'b0;
    guard = 0;
    while (k < 4 && guard < 100) begin
      out_ready = stall ? (c % 3 == 0) : 1'b1;
      c++;
      chk("drain_valid", out_valid, 1);
      chk("drain_in_ready", in_ready, 0);
      if (was_stalled) chk("stall_hold", out_data, held);
      if (out_ready) begin
        chk("out_data", out_data, exp[15-4*k -: 4]);
        chk("out_last", out_last, (k == 3));
        k++;
      end
      held = out_data;
      was_stalled = !out_ready;
      @(negedge clk);
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("word_count", k, 4);
    chk("post_valid", out_valid, 0);
    chk("post_last", out_last, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  initial begin
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_in_ready", in_ready, 1);

    // 1: mixed order, junk held on in_valid outside LOAD
    run_burst({4'b1110, 4'b1100, 4'b0010, 4'b0101},
              {4'b0010, 4'b0101, 4'b1100, 4'b1110}, -1, 1'b0, 1'b1);
    // 2: already sorted -> single clean pass
    run_burst({4'b0001, 4'b0010, 4'b0011, 4'b0100},
              {4'b0001, 4'b0010, 4'b0011, 4'b0100}, 3, 1'b0, 1'b0);
    // 3: reversed -> every pass runs
    run_burst({4'b1111, 4'b1000, 4'b0100, 4'b0000},
              {4'b0000, 4'b0100, 4'b1000, 4'b1111}, 6, 1'b0, 1'b0);
    // 4: duplicates
    run_burst({4'b0111, 4'b0110, 4'b0111, 4'b0000},
              {4'b0000, 4'b0110, 4'b0111, 4'b0111}, 6, 1'b0, 1'b0);
    // 5: backpressure 1,0,0 repeating
    run_burst({4'b1110, 4'b1100, 4'b0010, 4'b0101},
              {4'b0010, 4'b0101, 4'b1100, 4'b1110}, 6, 1'b1, 1'b0);

    // 6: reset during the second sort cycle, then a fresh burst
    load4({4'b1110, 4'b1100, 4'b0010, 4'b0101});
    chk("abort_busy_pre", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("abort_rel_in_ready", in_ready, 1);
    chk("abort_rel_valid", out_valid, 0);
    run_burst({4'b1000, 4'b0001, 4'b0100, 4'b0010},
              {4'b0001, 4'b0010, 4'b0100, 4'b1000}, -1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
